// File: rtl/riscv_hz_pkg.sv
// riscv_hz_pkg
// Shared definitions for the hazard/forwarding controller.
//   XLEN_DEF, AW_DEF : default datapath and register-address widths
//   REG_ZERO         : index of the hardwired-zero register
//   long_cnt_w()     : width needed to count 0..max_long outstanding ops
package riscv_hz_pkg;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int REG_ZERO = 0;

  function automatic int long_cnt_w(input int max_long);
    return $clog2(max_long + 1);
  endfunction
endpackage

// File: rtl/riscv_hz_fwd_mux.sv
// riscv_hz_fwd_mux
// Operand resolution for one decode read port.
//   rs_addr, rf_data           : source register and its register-file value
//   fwd_wr/addr/rdy/data       : in-pipeline sources, index 0 youngest
//   lwb_valid/addr/data        : long-latency writeback bypass
//   op_data                    : resolved operand
//   load_use                   : winning pipeline source has no data yet
module riscv_hz_fwd_mux
  import riscv_hz_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF,
  parameter int NFWD = 2
) (
  input  logic [AW-1:0]        rs_addr,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [NFWD-1:0]      fwd_wr,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 lwb_valid,
  input  logic [AW-1:0]        lwb_addr,
  input  logic [XLEN-1:0]      lwb_data,
  output logic [XLEN-1:0]      op_data,
  output logic                 load_use
);
  logic hit;

  // Youngest matching source wins; once a match is found older sources
  // are ignored, so a stale-but-ready older copy can never mask a load-use.
  always_comb begin
    op_data  = rf_data;
    load_use = 1'b0;
    hit      = 1'b0;
    if (rs_addr == AW'(REG_ZERO)) begin
      op_data = '0;
    end else begin
      for (int j = 0; j < NFWD; j++) begin
        if (!hit && fwd_wr[j] && fwd_addr[j*AW +: AW] == rs_addr) begin
          hit      = 1'b1;
          op_data  = fwd_data[j*XLEN +: XLEN];
          load_use = ~fwd_rdy[j];
        end
      end
      if (!hit && lwb_valid && lwb_addr == rs_addr) begin
        op_data = lwb_data;
      end
    end
  end
endmodule

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl
// Hazard and forwarding controller sitting beside decode.
//   clk, rstn                  : clock, synchronous active-low reset
//   id_*                       : decode instruction (sources, rd, long flag)
//   flush                      : kill the decode instruction this cycle
//   fwd_*                      : NFWD pipeline forwarding sources
//   lwb_*                      : long-latency writeback
//   op_data                    : resolved operands, port k at [k*XLEN +: XLEN]
//   stall / issue              : hold fetch/decode / instruction accepted
//   sb_pending, long_cnt       : scoreboard busy bits and outstanding count
//   err_underflow              : sticky, writeback with nothing outstanding
//   stall_cnt                  : saturating stall-cycle counter
module riscv_hazard_ctrl
  import riscv_hz_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int AW       = AW_DEF,
  parameter int NRD      = 2,
  parameter int NFWD     = 2,
  parameter int MAX_LONG = 4,
  parameter int CNT_W    = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            id_valid,
  input  logic [NRD*AW-1:0]               id_rs_addr,
  input  logic [NRD-1:0]                  id_rs_use,
  input  logic [NRD*XLEN-1:0]             id_rf_data,
  input  logic [AW-1:0]                   id_rd,
  input  logic                            id_wr,
  input  logic                            id_long,
  input  logic                            flush,
  input  logic [NFWD-1:0]                 fwd_wr,
  input  logic [NFWD*AW-1:0]              fwd_addr,
  input  logic [NFWD-1:0]                 fwd_rdy,
  input  logic [NFWD*XLEN-1:0]            fwd_data,
  input  logic                            lwb_valid,
  input  logic [AW-1:0]                   lwb_addr,
  input  logic [XLEN-1:0]                 lwb_data,
  output logic [NRD*XLEN-1:0]             op_data,
  output logic                            stall,
  output logic                            issue,
  output logic [2**AW-1:0]                sb_pending,
  output logic [long_cnt_w(MAX_LONG)-1:0] long_cnt,
  output logic                            err_underflow,
  output logic [CNT_W-1:0]                stall_cnt
);
  localparam int LCW  = long_cnt_w(MAX_LONG);
  localparam int NREG = 2**AW;

  logic [NRD-1:0]  load_use;
  logic [NRD-1:0]  port_haz;
  logic [NREG-1:0] lwb_hit;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_hit;
  logic [NREG-1:0] sb_next;
  logic            waw;
  logic            structural;
  logic            hazard;
  logic            live;
  logic            long_issue;

  // A writeback this cycle releases its register immediately, so readers
  // and writers of that register see it as free (data comes via the bypass).
  assign lwb_hit = lwb_valid ? (NREG'(1) << lwb_addr) : '0;
  assign busy    = sb_pending & ~lwb_hit;

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
      logic [AW-1:0] rs;
      assign rs = id_rs_addr[gi*AW +: AW];

      riscv_hz_fwd_mux #(
        .XLEN(XLEN), .AW(AW), .NFWD(NFWD)
      ) u_mux (
        .rs_addr  (rs),
        .rf_data  (id_rf_data[gi*XLEN +: XLEN]),
        .fwd_wr   (fwd_wr),
        .fwd_addr (fwd_addr),
        .fwd_rdy  (fwd_rdy),
        .fwd_data (fwd_data),
        .lwb_valid(lwb_valid),
        .lwb_addr (lwb_addr),
        .lwb_data (lwb_data),
        .op_data  (op_data[gi*XLEN +: XLEN]),
        .load_use (load_use[gi])
      );

      assign port_haz[gi] = id_rs_use[gi] & (rs != AW'(REG_ZERO)) &
                            (load_use[gi] | busy[rs]);
    end
  endgenerate

  assign waw        = id_wr & (id_rd != AW'(REG_ZERO)) & busy[id_rd];
  // A same-cycle writeback frees a slot, so a full tracker can still accept.
  assign structural = id_long & id_wr & (long_cnt == LCW'(MAX_LONG)) & ~lwb_valid;
  assign hazard     = (|port_haz) | waw | structural;
  assign live       = rstn & id_valid & ~flush;
  assign stall      = live & hazard;
  assign issue      = live & ~hazard;
  assign long_issue = issue & id_long & id_wr;

  // Set is applied after clear so a same-cycle reissue to the address wins.
  assign set_hit = (long_issue && id_rd != AW'(REG_ZERO)) ? (NREG'(1) << id_rd) : '0;
  assign sb_next = busy | set_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sb_pending    <= '0;
      long_cnt      <= '0;
      err_underflow <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      sb_pending <= sb_next;
      if (long_issue && !lwb_valid) begin
        long_cnt <= long_cnt + LCW'(1);
      end else if (!long_issue && lwb_valid && long_cnt != '0) begin
        long_cnt <= long_cnt - LCW'(1);
      end
      if (lwb_valid && long_cnt == '0) begin
        err_underflow <= 1'b1;
      end
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
endmodule
